// File: rtl/divider.sv
// Iterative 64-bit restoring divider for RV64M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional feature: define DIVIDER_EARLY_OUT_EN to skip the loop when the divisor is zero or exceeds the dividend.
module divider (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [63:0] dividend_i,
  input  logic [63:0] divisor_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [63:0] quotient_o,
  output logic [63:0] remainder_o,
  output logic        divzero_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [63:0] rem;
  logic [63:0] quo;
  logic [63:0] b_mag;
  logic [63:0] a_raw;
  logic        neg_q;
  logic        neg_r;
  logic        dz;
  logic [5:0]  counter;

  logic [63:0] a_mag_in;
  logic [63:0] b_mag_in;
  logic [64:0] rem_shift;
  logic [64:0] rem_sub;
  logic        rem_ge;
  logic        early_out;

  assign a_mag_in  = (signed_i && dividend_i[63]) ? (64'd0 - dividend_i) : dividend_i;
  assign b_mag_in  = (signed_i && divisor_i[63])  ? (64'd0 - divisor_i)  : divisor_i;

  // The partial remainder needs 65 bits after the shift; it always fits back in 64 after the subtract.
  assign rem_shift = {rem, quo[63]};
  assign rem_ge    = (rem_shift >= {1'b0, b_mag});
  assign rem_sub   = rem_shift - {1'b0, b_mag};

  // Early exit is decided on the first RUN cycle from registered magnitudes (quo still holds |a| there).
`ifdef DIVIDER_EARLY_OUT_EN
  assign early_out = (state == RUN) && (counter == 6'd63) && (dz || (quo < b_mag));
`else
  assign early_out = 1'b0;
`endif

  assign busy_o = (state == RUN) || (state == FIX);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (early_out || (counter == 6'd0)) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rem         <= 64'd0;
      quo         <= 64'd0;
      b_mag       <= 64'd0;
      a_raw       <= 64'd0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      counter     <= 6'd0;
      valid_o     <= 1'b0;
      quotient_o  <= 64'd0;
      remainder_o <= 64'd0;
      divzero_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            a_raw   <= dividend_i;
            b_mag   <= b_mag_in;
            quo     <= a_mag_in;
            rem     <= 64'd0;
            neg_q   <= signed_i & (dividend_i[63] ^ divisor_i[63]);
            neg_r   <= signed_i & dividend_i[63];
            dz      <= (divisor_i == 64'd0);
            counter <= 6'd63;
          end
        end
        RUN: begin
          if (early_out) begin
            rem <= quo;
            quo <= 64'd0;
          end else begin
            rem     <= rem_ge ? rem_sub[63:0] : rem_shift[63:0];
            quo     <= {quo[62:0], rem_ge};
            counter <= counter - 6'd1;
          end
        end
        FIX: begin
          // A zero divisor overrides the sign fix-up: all-ones quotient, dividend as remainder.
          quotient_o  <= dz ? 64'hFFFF_FFFF_FFFF_FFFF : (neg_q ? (64'd0 - quo) : quo);
          remainder_o <= dz ? a_raw : (neg_r ? (64'd0 - rem) : rem);
          divzero_o   <= dz;
          valid_o     <= 1'b1;
        end
        DONE: begin
          valid_o <= 1'b0;
        end
        default: begin
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
